bot_fet_gate_sequencer: RTL and testbench
=========================================

Name: bot_fet_gate_sequencer

Overview:
Sequences the gate of the low-side power NMOS (Kelvin-connected, source-replica current sense, gain 30) in the synchronous buck driver loop. It converts the PWM low-side request into a safe gate command with programmable dead time after top-switch turn-off and a leading-edge blanking window. It applies cycle-by-cycle over-current turn-off from the replica-current comparator and optional diode-emulation turn-off from the zero-cross comparator. Repeated over-current trips latch a fault. It sits between the PWM modulator and the low-side gate driver.

Parameters:
DT_W, 6, width of dead-time count
BLK_W, 6, width of blanking count
OCN_W, 4, width of consecutive over-current counter

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
EN  in  1  block enable; low forces gate off and clears fault
PWM_LO  in  1  low-side on request from the modulator, synchronous to CLK
HS_OFF  in  1  high-side gate confirmed off (interlock)
OC_CMP  in  1  replica current above limit, synchronous to CLK
ZC_CMP  in  1  inductor current crossed zero (reverse), synchronous to CLK
CFG_DT  in  DT_W  dead time; DEAD lasts CFG_DT+1 cycles
CFG_BLANK  in  BLK_W  blanking; BLANK lasts CFG_BLANK+1 cycles
CFG_OC_MAX  in  OCN_W  consecutive over-current trips that cause FAULT; 0 disables fault
CFG_DEMU  in  1  diode-emulation enable
GATE_ON  out  1  registered low-side gate command
LS_OFF  out  1  ~GATE_ON, interlock to the high-side sequencer
OC_TRIP  out  1  one-cycle pulse per over-current turn-off
FAULT  out  1  latched fault
OC_CNT  out  OCN_W  consecutive over-current count
STATE  out  3  IDLE=0 DEAD=1 BLANK=2 ON=3 LOCK=4 FLT=5

Behaviour:
- Reset values: STATE=IDLE, GATE_ON=0, LS_OFF=1, OC_TRIP=0, FAULT=0, OC_CNT=0, internal counter=0. Reset during any state takes effect at the next edge.
- GATE_ON is a flop loaded with (next_state is BLANK or ON). It is glitch-free and changes on the same edge as STATE.
- FAULT is 1 exactly while STATE=FLT.
- Config inputs are sampled when they are loaded into the counter, on entry to DEAD or BLANK.
- IDLE: if EN & PWM_LO & HS_OFF, go to DEAD and load cnt=CFG_DT.
- DEAD: if !EN or !PWM_LO or !HS_OFF, go to IDLE (abort). Else if cnt==0, go to BLANK and load cnt=CFG_BLANK. Else cnt--.
- Latency: with PWM_LO and HS_OFF sampled high at edge k, GATE_ON rises at edge k+CFG_DT+1.
- BLANK: OC_CMP and ZC_CMP are ignored.
  - If !HS_OFF, go to FLT (shoot-through).
  - Else if !EN or !PWM_LO, go to IDLE.
  - Else if cnt==0, go to ON.
  - Else cnt--.
- ON: conditions in priority order:
  1. !EN: go to IDLE.
  2. !HS_OFF: go to FLT.
  3. OC_CMP: OC_TRIP=1 for one cycle and OC_CNT is incremented, saturating at all-ones. If CFG_OC_MAX!=0 and the new count >= CFG_OC_MAX, go to FLT; otherwise go to LOCK.
  4. ZC_CMP & CFG_DEMU: go to LOCK. No OC_TRIP, OC_CNT unchanged.
  5. !PWM_LO: go to IDLE and clear OC_CNT (a clean cycle resets the consecutive count).
- LOCK: gate off. Go to IDLE when !PWM_LO or !EN; PWM_LO held high never re-arms the gate. OC_CNT is held.
- FLT: gate off. PWM_LO, OC_CMP, ZC_CMP and HS_OFF are ignored. Exit only on !EN (go to IDLE, clear OC_CNT) or on RST.
- Simultaneous events: OC beats PWM_LO falling, so the trip is counted. Shoot-through beats OC.
- ZC_CMP with CFG_DEMU=0 has no effect.
- An OC-terminated cycle never clears OC_CNT.

Test Plan:
1. CFG_DT=3, CFG_BLANK=2, EN=1, HS_OFF=1, PWM_LO rises before edge 0 -> STATE 1 at edges 0-3, GATE_ON=1 and STATE=2 from edge 4, STATE=3 from edge 7. PWM_LO falls -> GATE_ON=0 and LS_OFF=1 at the next edge.
2. PWM_LO=1 with HS_OFF=0 for 10 cycles -> stays IDLE, GATE_ON=0. HS_OFF rises -> DEAD entered at the next edge. HS_OFF falls mid-DEAD -> IDLE, GATE_ON never asserts.
3. OC_CMP pulsed during BLANK -> ignored. OC_CMP in ON -> GATE_ON=0 at the next edge, OC_TRIP single pulse, OC_CNT=1, STATE=4 while PWM_LO stays high. The next PWM period turns on normally.
4. CFG_OC_MAX=3: OC in three consecutive periods -> FAULT=1 and STATE=5 on the third trip, and later PWM periods keep GATE_ON=0. EN low for 1 cycle -> IDLE, OC_CNT=0. Separately, OC, then a clean period, then OC -> OC_CNT=1 and no fault.
5. CFG_DEMU=1, ZC_CMP in ON -> GATE_ON=0, STATE=4, no OC_TRIP, OC_CNT unchanged. CFG_DEMU=0 -> ZC ignored, gate stays on until PWM_LO falls.
6. Fault and reset paths:
   - HS_OFF drops while in ON -> STATE=5, GATE_ON=0 at the next edge.
   - RST asserted in ON -> all outputs at reset values at the next edge.
   - Simultaneous OC_CMP and PWM_LO fall -> OC_TRIP=1, OC_CNT incremented.

Source files
------------

// File: rtl/bot_fet_gate_sequencer_if.sv
// Signal bundle between the PWM modulator side and the low-side gate sequencer.
// The master drives requests, comparators and configuration; the slave returns gate command and status.
interface bot_fet_gate_sequencer_if #(
    parameter int DT_W  = 6,
    parameter int BLK_W = 6,
    parameter int OCN_W = 4
);
    logic             EN;
    logic             PWM_LO;
    logic             HS_OFF;
    logic             OC_CMP;
    logic             ZC_CMP;
    logic [DT_W-1:0]  CFG_DT;
    logic [BLK_W-1:0] CFG_BLANK;
    logic [OCN_W-1:0] CFG_OC_MAX;
    logic             CFG_DEMU;
    logic             GATE_ON;
    logic             LS_OFF;
    logic             OC_TRIP;
    logic             FAULT;
    logic [OCN_W-1:0] OC_CNT;
    logic [2:0]       STATE;

    modport master (
        output EN, PWM_LO, HS_OFF, OC_CMP, ZC_CMP,
        output CFG_DT, CFG_BLANK, CFG_OC_MAX, CFG_DEMU,
        input  GATE_ON, LS_OFF, OC_TRIP, FAULT, OC_CNT, STATE
    );

    modport slave (
        input  EN, PWM_LO, HS_OFF, OC_CMP, ZC_CMP,
        input  CFG_DT, CFG_BLANK, CFG_OC_MAX, CFG_DEMU,
        output GATE_ON, LS_OFF, OC_TRIP, FAULT, OC_CNT, STATE
    );
endinterface

// File: rtl/bot_fet_gate_sequencer.sv
// Low-side NMOS gate sequencer: dead time, leading-edge blanking, cycle-by-cycle
// over-current turn-off, diode-emulation turn-off and latched fault on repeated trips.
module bot_fet_gate_sequencer #(
    parameter int DT_W  = 6,
    parameter int BLK_W = 6,
    parameter int OCN_W = 4
) (
    input logic                    CLK,
    input logic                    RST,
    bot_fet_gate_sequencer_if.slave bus
);
    localparam int CNT_W = (DT_W > BLK_W) ? DT_W : BLK_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DEAD  = 3'd1,
        BLANK = 3'd2,
        ON    = 3'd3,
        LOCK  = 3'd4,
        FLT   = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OCN_W-1:0] oc_cnt_q, oc_cnt_d;
    logic [OCN_W-1:0] oc_cnt_inc;
    logic             oc_trip_q, oc_trip_d;
    logic             gate_q;
    logic             fault_q;

    assign oc_cnt_inc = (oc_cnt_q == '1) ? oc_cnt_q : oc_cnt_q + 1'b1;

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path leaves one unassigned (no latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        oc_cnt_d  = oc_cnt_q;
        oc_trip_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.EN && bus.PWM_LO && bus.HS_OFF) begin
                    state_d = DEAD;
                    cnt_d   = CNT_W'(bus.CFG_DT);
                end
            end
            DEAD: begin
                if (!bus.EN || !bus.PWM_LO || !bus.HS_OFF) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = BLANK;
                    cnt_d   = CNT_W'(bus.CFG_BLANK);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BLANK: begin
                // Comparators are blind here; only the interlock and request matter.
                if (!bus.HS_OFF) begin
                    state_d = FLT;
                end else if (!bus.EN || !bus.PWM_LO) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ON;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ON: begin
                if (!bus.EN) begin
                    state_d = IDLE;
                end else if (!bus.HS_OFF) begin
                    state_d = FLT;
                end else if (bus.OC_CMP) begin
                    oc_trip_d = 1'b1;
                    oc_cnt_d  = oc_cnt_inc;
                    if (bus.CFG_OC_MAX != '0 && oc_cnt_inc >= bus.CFG_OC_MAX) state_d = FLT;
                    else                                                      state_d = LOCK;
                end else if (bus.ZC_CMP && bus.CFG_DEMU) begin
                    state_d = LOCK;
                end else if (!bus.PWM_LO) begin
                    // A period that ends cleanly breaks the consecutive-trip run.
                    state_d  = IDLE;
                    oc_cnt_d = '0;
                end
            end
            LOCK: begin
                if (!bus.PWM_LO || !bus.EN) state_d = IDLE;
            end
            FLT: begin
                if (!bus.EN) begin
                    state_d  = IDLE;
                    oc_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            oc_cnt_q  <= '0;
            oc_trip_q <= 1'b0;
            gate_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            oc_cnt_q  <= oc_cnt_d;
            oc_trip_q <= oc_trip_d;
            gate_q    <= (state_d == BLANK) || (state_d == ON);
            fault_q   <= (state_d == FLT);
        end
    end

    assign bus.GATE_ON = gate_q;
    assign bus.LS_OFF  = ~gate_q;
    assign bus.OC_TRIP = oc_trip_q;
    assign bus.FAULT   = fault_q;
    assign bus.OC_CNT  = oc_cnt_q;
    assign bus.STATE   = state_q;
endmodule

// File: tb/tb_bot_fet_gate_sequencer.sv
// Directed bench for the low-side gate sequencer with hand-computed expectations.
module tb_bot_fet_gate_sequencer;
    localparam int DT_W  = 6;
    localparam int BLK_W = 6;
    localparam int OCN_W = 4;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    bot_fet_gate_sequencer_if #(.DT_W(DT_W), .BLK_W(BLK_W), .OCN_W(OCN_W)) bus ();

    bot_fet_gate_sequencer #(.DT_W(DT_W), .BLK_W(BLK_W), .OCN_W(OCN_W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(bus.STATE), 0);
        chk({tag, "_gate"}, 32'(bus.GATE_ON), 0);
        chk({tag, "_lsoff"}, 32'(bus.LS_OFF), 1);
        chk({tag, "_trip"}, 32'(bus.OC_TRIP), 0);
        chk({tag, "_fault"}, 32'(bus.FAULT), 0);
        chk({tag, "_occnt"}, 32'(bus.OC_CNT), 0);
    endtask

    // DT=3, BLANK=2: PWM_LO sampled at edge 0 reaches ON at edge 7.
    task automatic run_to_on(input string tag);
        bus.PWM_LO = 1'b1;
        repeat (8) tick();
        chk({tag, "_on_state"}, 32'(bus.STATE), 3);
        chk({tag, "_on_gate"}, 32'(bus.GATE_ON), 1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst            = 1'b1;
        bus.EN         = 1'b1;
        bus.PWM_LO     = 1'b0;
        bus.HS_OFF     = 1'b1;
        bus.OC_CMP     = 1'b0;
        bus.ZC_CMP     = 1'b0;
        bus.CFG_DT     = 6'd3;
        bus.CFG_BLANK  = 6'd2;
        bus.CFG_OC_MAX = 4'd0;
        bus.CFG_DEMU   = 1'b0;
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Basic turn-on sequence and latency
        bus.PWM_LO = 1'b1;
        for (int e = 0; e <= 3; e++) begin
            tick();
            chk($sformatf("t1_dead_e%0d", e), 32'(bus.STATE), 1);
            chk($sformatf("t1_gate_e%0d", e), 32'(bus.GATE_ON), 0);
        end
        for (int e = 4; e <= 6; e++) begin
            tick();
            chk($sformatf("t1_blank_e%0d", e), 32'(bus.STATE), 2);
            chk($sformatf("t1_gate_e%0d", e), 32'(bus.GATE_ON), 1);
        end
        tick();
        chk("t1_on_e7", 32'(bus.STATE), 3);
        chk("t1_lsoff_on", 32'(bus.LS_OFF), 0);
        bus.PWM_LO = 1'b0;
        tick();
        chk("t1_off_gate", 32'(bus.GATE_ON), 0);
        chk("t1_off_lsoff", 32'(bus.LS_OFF), 1);
        chk("t1_off_state", 32'(bus.STATE), 0);

        // Interlock holds the sequencer in IDLE
        bus.HS_OFF = 1'b0;
        bus.PWM_LO = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("t2_hold_state_%0d", i), 32'(bus.STATE), 0);
            chk($sformatf("t2_hold_gate_%0d", i), 32'(bus.GATE_ON), 0);
        end
        bus.HS_OFF = 1'b1;
        tick();
        chk("t2_dead_entry", 32'(bus.STATE), 1);
        tick();
        chk("t2_dead_mid", 32'(bus.STATE), 1);
        bus.HS_OFF = 1'b0;
        tick();
        chk("t2_abort_state", 32'(bus.STATE), 0);
        chk("t2_abort_gate", 32'(bus.GATE_ON), 0);
        bus.HS_OFF = 1'b1;
        bus.PWM_LO = 1'b0;
        tick();

        // Over-current: blanked, then trip in ON
        bus.PWM_LO = 1'b1;
        repeat (5) tick();
        chk("t3_in_blank", 32'(bus.STATE), 2);
        bus.OC_CMP = 1'b1;
        tick();
        chk("t3_blank_ignore_state", 32'(bus.STATE), 2);
        chk("t3_blank_ignore_trip", 32'(bus.OC_TRIP), 0);
        bus.OC_CMP = 1'b0;
        tick();
        tick();
        chk("t3_on", 32'(bus.STATE), 3);
        bus.OC_CMP = 1'b1;
        tick();
        chk("t3_trip_gate", 32'(bus.GATE_ON), 0);
        chk("t3_trip_pulse", 32'(bus.OC_TRIP), 1);
        chk("t3_trip_cnt", 32'(bus.OC_CNT), 1);
        chk("t3_trip_state", 32'(bus.STATE), 4);
        bus.OC_CMP = 1'b0;
        tick();
        chk("t3_trip_pulse_end", 32'(bus.OC_TRIP), 0);
        chk("t3_lock_hold", 32'(bus.STATE), 4);
        tick();
        chk("t3_lock_hold2", 32'(bus.GATE_ON), 0);
        bus.PWM_LO = 1'b0;
        tick();
        chk("t3_lock_exit", 32'(bus.STATE), 0);
        chk("t3_lock_cnt_held", 32'(bus.OC_CNT), 1);
        run_to_on("t3_next");
        bus.PWM_LO = 1'b0;
        tick();
        chk("t3_clean_clear", 32'(bus.OC_CNT), 0);

        // Consecutive trips latch a fault
        bus.CFG_OC_MAX = 4'd3;
        for (int p = 1; p <= 2; p++) begin
            run_to_on($sformatf("t4_p%0d", p));
            bus.OC_CMP = 1'b1;
            tick();
            chk($sformatf("t4_p%0d_cnt", p), 32'(bus.OC_CNT), 32'(p));
            chk($sformatf("t4_p%0d_state", p), 32'(bus.STATE), 4);
            bus.OC_CMP = 1'b0;
            bus.PWM_LO = 1'b0;
            tick();
        end
        run_to_on("t4_p3");
        bus.OC_CMP = 1'b1;
        tick();
        chk("t4_fault_state", 32'(bus.STATE), 5);
        chk("t4_fault_flag", 32'(bus.FAULT), 1);
        chk("t4_fault_cnt", 32'(bus.OC_CNT), 3);
        chk("t4_fault_trip", 32'(bus.OC_TRIP), 1);
        bus.OC_CMP = 1'b0;
        bus.PWM_LO = 1'b0;
        tick();
        bus.PWM_LO = 1'b1;
        repeat (10) tick();
        chk("t4_fault_hold_state", 32'(bus.STATE), 5);
        chk("t4_fault_hold_gate", 32'(bus.GATE_ON), 0);
        bus.EN = 1'b0;
        tick();
        chk("t4_clear_state", 32'(bus.STATE), 0);
        chk("t4_clear_cnt", 32'(bus.OC_CNT), 0);
        chk("t4_clear_fault", 32'(bus.FAULT), 0);
        bus.EN = 1'b1;
        bus.PWM_LO = 1'b0;
        tick();
        run_to_on("t4_sep1");
        bus.OC_CMP = 1'b1;
        tick();
        chk("t4_sep1_cnt", 32'(bus.OC_CNT), 1);
        bus.OC_CMP = 1'b0;
        bus.PWM_LO = 1'b0;
        tick();
        run_to_on("t4_sep2");
        bus.PWM_LO = 1'b0;
        tick();
        chk("t4_sep2_clean", 32'(bus.OC_CNT), 0);
        run_to_on("t4_sep3");
        bus.OC_CMP = 1'b1;
        tick();
        chk("t4_sep3_cnt", 32'(bus.OC_CNT), 1);
        chk("t4_sep3_nofault", 32'(bus.FAULT), 0);
        chk("t4_sep3_state", 32'(bus.STATE), 4);
        bus.OC_CMP = 1'b0;
        bus.PWM_LO = 1'b0;
        tick();

        // Diode emulation
        bus.CFG_OC_MAX = 4'd0;
        bus.CFG_DEMU = 1'b1;
        run_to_on("t5_demu");
        bus.ZC_CMP = 1'b1;
        tick();
        chk("t5_zc_gate", 32'(bus.GATE_ON), 0);
        chk("t5_zc_state", 32'(bus.STATE), 4);
        chk("t5_zc_notrip", 32'(bus.OC_TRIP), 0);
        chk("t5_zc_cnt", 32'(bus.OC_CNT), 1);
        bus.ZC_CMP = 1'b0;
        bus.PWM_LO = 1'b0;
        tick();
        bus.CFG_DEMU = 1'b0;
        run_to_on("t5_nodemu");
        bus.ZC_CMP = 1'b1;
        tick();
        chk("t5_zc_ignored_state", 32'(bus.STATE), 3);
        tick();
        chk("t5_zc_ignored_gate", 32'(bus.GATE_ON), 1);
        bus.ZC_CMP = 1'b0;
        bus.PWM_LO = 1'b0;
        tick();
        chk("t5_off_gate", 32'(bus.GATE_ON), 0);
        chk("t5_off_cnt", 32'(bus.OC_CNT), 0);

        // Shoot-through, reset, simultaneous events
        run_to_on("t6_st");
        bus.HS_OFF = 1'b0;
        tick();
        chk("t6_st_state", 32'(bus.STATE), 5);
        chk("t6_st_gate", 32'(bus.GATE_ON), 0);
        chk("t6_st_fault", 32'(bus.FAULT), 1);
        bus.HS_OFF = 1'b1;
        bus.PWM_LO = 1'b0;
        bus.EN = 1'b0;
        tick();
        bus.EN = 1'b1;
        tick();
        run_to_on("t6_rst");
        rst = 1'b1;
        tick();
        chk_reset_vals("t6_rst");
        rst = 1'b0;
        bus.PWM_LO = 1'b0;
        tick();
        run_to_on("t6_sim");
        bus.OC_CMP = 1'b1;
        bus.PWM_LO = 1'b0;
        tick();
        chk("t6_sim_trip", 32'(bus.OC_TRIP), 1);
        chk("t6_sim_cnt", 32'(bus.OC_CNT), 1);
        chk("t6_sim_state", 32'(bus.STATE), 4);
        bus.OC_CMP = 1'b0;
        tick();
        chk("t6_sim_idle", 32'(bus.STATE), 0);
        run_to_on("t6_st_oc");
        bus.HS_OFF = 1'b0;
        bus.OC_CMP = 1'b1;
        tick();
        chk("t6_st_oc_state", 32'(bus.STATE), 5);
        chk("t6_st_oc_notrip", 32'(bus.OC_TRIP), 0);
        chk("t6_st_oc_cnt", 32'(bus.OC_CNT), 1);
        bus.HS_OFF = 1'b1;
        bus.OC_CMP = 1'b0;
        bus.EN = 1'b0;
        tick();
        chk("t6_final_cnt", 32'(bus.OC_CNT), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
